// File: rtl/code_memory_param_if.sv
// Fetch, loader and default-image ROM signals of the parametrised i281 code memory.
// The memory takes the slave modport; the fetch/loader/ROM side takes the master modport.
interface code_memory_param_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
);
    logic              run;
    logic [ADDR_W-1:0] read_addr;
    logic [DATA_W:0]   curr_instruction;
    logic              multicycle_flag;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_flag;
    logic              wr_err;
    logic              restore_req;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W:0]   rom_data;
    logic              busy;

    modport slave (
        input  run, read_addr, wr_valid, wr_addr, wr_data, wr_flag, restore_req, rom_data,
        output curr_instruction, multicycle_flag, wr_ready, wr_err, rom_addr, busy
    );

    modport master (
        output run, read_addr, wr_valid, wr_addr, wr_data, wr_flag, restore_req, rom_data,
        input  curr_instruction, multicycle_flag, wr_ready, wr_err, rom_addr, busy
    );
endinterface

// File: rtl/code_memory_param.sv
// Parametrised i281 instruction memory: copies the default image from ROM, serves fetches, accepts loader writes.
// Optional BIOS write protection is enabled by defining CODEMEM_BIOS_PROTECT_EN.
module code_memory_param #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 16,
    parameter int BIOS_WORDS = 32
) (
    input  logic                clock,
    input  logic                reset,
    code_memory_param_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [0:0] ST_RESTORE = 1'b0;
    localparam logic [0:0] ST_IDLE    = 1'b1;

    localparam logic [ADDR_W:0] LAST_INDEX = (ADDR_W+1)'(DEPTH - 1);

    if (BIOS_WORDS < 0 || BIOS_WORDS > DEPTH) begin : g_bad_bios_words
        $error("BIOS_WORDS must lie in 0..DEPTH");
    end

    logic [DATA_W:0]   mem [DEPTH];

    logic [0:0]        state_q, state_d;
    logic [ADDR_W:0]   index_q, index_d;
    logic [DATA_W:0]   curr_q;
    logic              flag_q;
    logic              restoring;
    logic              wr_fire;
    logic              wr_commit;

    assign restoring = (state_q == ST_RESTORE);
    assign wr_fire   = bus.wr_valid && !restoring;

`ifdef CODEMEM_BIOS_PROTECT_EN
    localparam logic [ADDR_W:0] BIOS_LIMIT = (ADDR_W+1)'(BIOS_WORDS);

    logic wr_blocked;
    logic wr_err_q;

    assign wr_blocked = wr_fire && ({1'b0, bus.wr_addr} < BIOS_LIMIT);
    assign wr_commit  = wr_fire && !wr_blocked;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_blocked;
        end
    end

    assign bus.wr_err = wr_err_q;
`else
    assign wr_commit  = wr_fire;
    assign bus.wr_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        if (restoring) begin
            index_d = index_q + 1'b1;
            if (index_q == LAST_INDEX) begin
                state_d = ST_IDLE;
                index_d = '0;
            end
        end else if (bus.restore_req) begin
            state_d = ST_RESTORE;
            index_d = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_RESTORE;
            index_q <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
        end
    end

    // NOTE: the storage array has no reset; the restore sequence defines its contents.
    always_ff @(posedge clock) begin
        if (restoring) begin
            mem[index_q[ADDR_W-1:0]] <= bus.rom_data;
        end else if (wr_commit) begin
            mem[bus.wr_addr] <= {bus.wr_flag, bus.wr_data};
        end
    end

    // NOTE: non-blocking updates let a same-edge read see the word before the write lands.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            curr_q <= '0;
            flag_q <= 1'b0;
        end else if (!restoring && bus.run) begin
            curr_q <= mem[bus.read_addr];
            flag_q <= mem[bus.read_addr][DATA_W];
        end
    end

    assign bus.curr_instruction = curr_q;
    assign bus.multicycle_flag  = flag_q;
    assign bus.busy             = restoring;
    assign bus.wr_ready         = !restoring;
    assign bus.rom_addr         = restoring ? index_q[ADDR_W-1:0] : '0;
endmodule

// File: tb/tb_code_memory_param.sv
// Directed bench for code_memory_param: restore timing, fetch, loader writes, protection, mid-restore reset.
module tb_code_memory_param;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 16;

`ifdef CODEMEM_BIOS_PROTECT_EN
    localparam bit PROTECT = 1'b1;
`else
    localparam bit PROTECT = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    code_memory_param_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    code_memory_param #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BIOS_WORDS(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Default image ROM: {0, A000 + address}.
    assign bus.rom_data = {1'b0, 16'hA000 + {10'd0, bus.rom_addr}};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic read_word(input logic [ADDR_W-1:0] addr, output logic [DATA_W:0] val);
        bus.run       = 1'b1;
        bus.read_addr = addr;
        step();
        val     = bus.curr_instruction;
        bus.run = 1'b0;
    endtask

    task automatic write_word(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                              input logic flag, output logic err);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = addr;
        bus.wr_data  = data;
        bus.wr_flag  = flag;
        step();
        err          = bus.wr_err;
        bus.wr_valid = 1'b0;
    endtask

    task automatic wait_restore(input string tag, output int cycles);
        cycles = 0;
        while (bus.busy && cycles < 200) begin
            step();
            cycles++;
        end
        check(tag, cycles, 64);
    endtask

    initial begin
        logic [DATA_W:0] val;
        logic            err;
        int              cycles;
        int              not_ready;

        bus.run         = 1'b0;
        bus.read_addr   = '0;
        bus.wr_valid    = 1'b0;
        bus.wr_addr     = '0;
        bus.wr_data     = '0;
        bus.wr_flag     = 1'b0;
        bus.restore_req = 1'b0;

        step();
        step();
        check("rst_busy", bus.busy, 1);
        check("rst_ready", bus.wr_ready, 0);
        check("rst_curr", bus.curr_instruction, 0);
        check("rst_mflag", bus.multicycle_flag, 0);
        check("rst_wr_err", bus.wr_err, 0);
        check("rst_rom_addr", bus.rom_addr, 0);

        // Initial restore, with a probe of the ROM address three cycles in.
        reset = 1'b0;
        cycles = 0;
        while (bus.busy && cycles < 200) begin
            if (cycles == 3) check("restore_rom_addr", bus.rom_addr, 3);
            step();
            cycles++;
        end
        check("restore_len", cycles, 64);
        check("idle_rom_addr", bus.rom_addr, 0);

        read_word(6'd5, val);
        check("read5", val, 17'h0A005);
        check("read5_mflag", bus.multicycle_flag, 0);

        // Loader write with a same-cycle read of the same address.
        bus.run       = 1'b1;
        bus.read_addr = 6'd40;
        write_word(6'd40, 16'h1234, 1'b1, err);
        check("rbw_old", bus.curr_instruction, 17'h0A028);
        check("wr40_err", err, 0);
        step();
        bus.run = 1'b0;
        check("read40", bus.curr_instruction, 17'h11234);
        check("read40_mflag", bus.multicycle_flag, 1);

        // Outputs hold while run is low.
        bus.read_addr = 6'd5;
        step();
        step();
        step();
        check("hold_curr", bus.curr_instruction, 17'h11234);
        check("hold_mflag", bus.multicycle_flag, 1);

        // BIOS region protection (address 10 and boundary 31), address 32 always writable.
        write_word(6'd10, 16'hFFFF, 1'b0, err);
        check("wr10_err", err, PROTECT);
        step();
        check("wr10_err_pulse", bus.wr_err, 0);
        read_word(6'd10, val);
        check("read10", val, PROTECT ? 17'h0A00A : 17'h0FFFF);

        write_word(6'd31, 16'h0BAD, 1'b0, err);
        check("wr31_err", err, PROTECT);
        read_word(6'd31, val);
        check("read31", val, PROTECT ? 17'h0A01F : 17'h00BAD);

        write_word(6'd32, 16'h5555, 1'b1, err);
        check("wr32_err", err, 0);
        read_word(6'd32, val);
        check("read32", val, 17'h15555);

        // User edit, then restore requested with a write held pending across it.
        write_word(6'd50, 16'hBEEF, 1'b1, err);
        read_word(6'd50, val);
        check("read50_edit", val, 17'h1BEEF);

        bus.wr_valid    = 1'b1;
        bus.wr_addr     = 6'd51;
        bus.wr_data     = 16'h7777;
        bus.wr_flag     = 1'b0;
        bus.restore_req = 1'b1;
        step();
        bus.restore_req = 1'b0;
        bus.run         = 1'b1;
        bus.read_addr   = 6'd0;
        cycles    = 0;
        not_ready = 0;
        while (bus.busy && cycles < 200) begin
            if (bus.wr_ready) not_ready++;
            step();
            cycles++;
        end
        bus.run = 1'b0;
        check("req_restore_len", cycles, 64);
        check("ready_low_during_restore", not_ready, 0);
        check("curr_held_in_restore", bus.curr_instruction, 17'h1BEEF);
        check("ready_after_restore", bus.wr_ready, 1);
        step();
        bus.wr_valid = 1'b0;
        read_word(6'd51, val);
        check("read51_pending_wr", val, 17'h07777);
        read_word(6'd50, val);
        check("read50_restored", val, 17'h0A032);
        read_word(6'd40, val);
        check("read40_restored", val, 17'h0A028);

        // Reset in the middle of a restore restarts it from index 0.
        bus.restore_req = 1'b1;
        step();
        bus.restore_req = 1'b0;
        cycles = 0;
        while (bus.rom_addr != 6'd20 && cycles < 100) begin
            step();
            cycles++;
        end
        check("reached_index20", bus.rom_addr, 20);
        reset = 1'b1;
        #1;
        check("midrst_busy", bus.busy, 1);
        check("midrst_rom_addr", bus.rom_addr, 0);
        check("midrst_curr", bus.curr_instruction, 0);
        step();
        reset = 1'b0;
        wait_restore("midrst_restore_len", cycles);

        for (int i = 0; i < 64; i++) begin
            read_word(ADDR_W'(i), val);
            check($sformatf("rom_word%0d", i), val, {1'b0, 16'hA000 + 16'(i)});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
